// File: rtl/miner_pkg.sv
// Shared definitions for the nonce scheduler: FSM state encoding and default widths.
package miner_pkg;
   localparam int NONCE_W_DEF = 32;
   localparam int HASH_W_DEF  = 256;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_e;
endpackage

// File: rtl/nonce_scheduler_if.sv
// Job handshake between the nonce scheduler (master) and the SHA-256 hash core (slave).
interface nonce_scheduler_if
   import miner_pkg::*;
#(
   parameter int NONCE_W = NONCE_W_DEF,
   parameter int HASH_W  = HASH_W_DEF
) ();
   logic               core_ready;
   logic               core_start;
   logic [NONCE_W-1:0] core_nonce;
   logic               core_done;
   logic [HASH_W-1:0]  core_hash;

   modport master (input core_ready, core_done, core_hash, output core_start, core_nonce);
   modport slave  (output core_ready, core_done, core_hash, input core_start, core_nonce);
endinterface

// File: rtl/nonce_scheduler_target_check.sv
// Registered unsigned compare hit = (hash <= target); result is valid the cycle after en.
module target_check
   import miner_pkg::*;
#(
   parameter int HASH_W = HASH_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [HASH_W-1:0] hash,
   input  logic [HASH_W-1:0] target,
   output logic              hit
);
   logic hit_q, hit_d;

   always_comb begin
      hit_d = hit_q;
      if (en) hit_d = (hash <= target);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hit_q <= 1'b0;
      else        hit_q <= hit_d;
   end

   assign hit = hit_q;
endmodule

// File: rtl/nonce_scheduler.sv
// Walks a nonce range through the hash core and records the first hash at or below target.
// Build option MULTI_HIT_EN: keep searching after a hit and count hits in hit_count.
module nonce_scheduler
   import miner_pkg::*;
#(
   parameter int NONCE_W = NONCE_W_DEF,
   parameter int HASH_W  = HASH_W_DEF
`ifdef MULTI_HIT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [HASH_W-1:0]  target,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_end,
   nonce_scheduler_if.master  core,
   output logic               busy,
   output logic               found,
   output logic [NONCE_W-1:0] found_nonce,
   output logic [HASH_W-1:0]  found_hash,
   output logic               exhausted
`ifdef MULTI_HIT_EN
   , output logic [CNT_W-1:0] hit_count
`endif
);
   state_e             state_q, state_d;
   logic [HASH_W-1:0]  tgt_q, tgt_d, hash_q, hash_d, found_hash_q, found_hash_d;
   logic [NONCE_W-1:0] cur_q, cur_d, end_q, end_d, found_nonce_q, found_nonce_d;
   logic               core_start_q, core_start_d;
   logic               found_q, found_d, exhausted_q, exhausted_d;
   logic               hit;
`ifdef MULTI_HIT_EN
   logic [CNT_W-1:0]   hit_count_q, hit_count_d;
`endif

   // The compare is registered on the core_done edge so hit is ready during CHECK.
   target_check #(.HASH_W(HASH_W)) u_check (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     ((state_q == WAIT) && core.core_done && !abort),
      .hash   (core.core_hash),
      .target (tgt_q),
      .hit    (hit)
   );

   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      hash_d        = hash_q;
      cur_d         = cur_q;
      end_d         = end_q;
      core_start_d  = 1'b0;
      found_d       = found_q;
      found_nonce_d = found_nonce_q;
      found_hash_d  = found_hash_q;
      exhausted_d   = exhausted_q;
`ifdef MULTI_HIT_EN
      hit_count_d   = hit_count_q;
`endif
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_d     = ISSUE;
               tgt_d       = target;
               cur_d       = nonce_start;
               end_d       = nonce_end;
               found_d     = 1'b0;
               exhausted_d = 1'b0;
`ifdef MULTI_HIT_EN
               hit_count_d = '0;
`endif
            end
            ISSUE: if (core.core_ready) begin
               core_start_d = 1'b1;
               state_d      = WAIT;
            end
            WAIT: if (core.core_done) begin
               hash_d  = core.core_hash;
               state_d = CHECK;
            end
            CHECK: begin
               if (hit && !found_q) begin
                  found_d       = 1'b1;
                  found_nonce_d = cur_q;
                  found_hash_d  = hash_q;
               end
`ifdef MULTI_HIT_EN
               if (hit && (hit_count_q != '1)) hit_count_d = hit_count_q + 1'b1;
               if (cur_q == end_q) begin
                  exhausted_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = ISSUE;
               end
`else
               // The end test runs first so a hit on nonce_end still reports exhausted.
               if (cur_q == end_q) begin
                  exhausted_d = 1'b1;
                  state_d     = IDLE;
               end else if (hit) begin
                  state_d = IDLE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = ISSUE;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         tgt_q         <= '0;
         hash_q        <= '0;
         cur_q         <= '0;
         end_q         <= '0;
         core_start_q  <= 1'b0;
         found_q       <= 1'b0;
         found_nonce_q <= '0;
         found_hash_q  <= '0;
         exhausted_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         tgt_q         <= tgt_d;
         hash_q        <= hash_d;
         cur_q         <= cur_d;
         end_q         <= end_d;
         core_start_q  <= core_start_d;
         found_q       <= found_d;
         found_nonce_q <= found_nonce_d;
         found_hash_q  <= found_hash_d;
         exhausted_q   <= exhausted_d;
      end
   end

`ifdef MULTI_HIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hit_count_q <= '0;
      else        hit_count_q <= hit_count_d;
   end
   assign hit_count = hit_count_q;
`endif

   assign core.core_start = core_start_q;
   assign core.core_nonce = cur_q;
   assign busy            = (state_q != IDLE);
   assign found           = found_q;
   assign found_nonce     = found_nonce_q;
   assign found_hash      = found_hash_q;
   assign exhausted       = exhausted_q;
endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler: a reference search model queues expected nonces and
// end-of-search results; a monitor pops and compares as the DUT issues jobs and goes idle.
module tb_nonce_scheduler;
   localparam int NW = 32;
   localparam int HW = 256;
`ifdef MULTI_HIT_EN
   localparam bit MULTI = 1'b1;
`else
   localparam bit MULTI = 1'b0;
`endif

   typedef struct packed {
      logic          found;
      logic [31:0]   fn;
      logic [255:0]  fh;
      logic          exh;
      logic [15:0]   cnt;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [HW-1:0] target = '0;
   logic [NW-1:0] nonce_start = '0;
   logic [NW-1:0] nonce_end = '0;
   logic          busy, found, exhausted;
   logic [NW-1:0] found_nonce;
   logic [HW-1:0] found_hash;
`ifdef MULTI_HIT_EN
   logic [15:0]   hit_count;
`endif

   nonce_scheduler_if #(.NONCE_W(NW), .HASH_W(HW)) cif ();

   nonce_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .target      (target),
      .nonce_start (nonce_start),
      .nonce_end   (nonce_end),
      .core        (cif),
      .busy        (busy),
      .found       (found),
      .found_nonce (found_nonce),
      .found_hash  (found_hash),
      .exhausted   (exhausted)
`ifdef MULTI_HIT_EN
      , .hit_count (hit_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hash core behaviour: pseudo-random hashes, or all-ones except a chosen hit set.
   int          hmode = 0;
   logic [31:0] salt = 32'h1234_5677;
   logic [31:0] hitset[$];

   function automatic logic [255:0] hash_of(input logic [31:0] n);
      if (hmode == 0) return {8{n * 32'h9E37_79B9 + salt}};
      foreach (hitset[i]) if (hitset[i] == n) return {224'h0, n};
      return '1;
   endfunction

   // Reference model: which nonces get issued, and how the search ends.
   res_t        m = '0;
   logic [31:0] exp_nonce_q[$];
   res_t        exp_res_q[$];

   task automatic model_search(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
      logic [31:0]  n;
      logic [255:0] h;
      n = s;
      m.found = 1'b0;
      m.exh   = 1'b0;
      m.cnt   = '0;
      for (int k = 0; k < 64; k++) begin
         exp_nonce_q.push_back(n);
         h = hash_of(n);
         if (h <= t) begin
            if (!m.found) begin
               m.found = 1'b1;
               m.fn    = n;
               m.fh    = h;
            end
            if (m.cnt != 16'hFFFF) m.cnt++;
            if (n == e) begin m.exh = 1'b1; break; end
            if (!MULTI) break;
         end else if (n == e) begin
            m.exh = 1'b1;
            break;
         end
         n = n + 32'd1;
      end
      exp_res_q.push_back(m);
   endtask

   // core_ready driver: 0 = always ready, 1 = random, 2 = held low.
   int ready_mode = 0;
   initial begin
      cif.core_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         cif.core_ready = (ready_mode == 0) ? 1'b1 :
                          (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   // Hash core model: answers each job after 1..core_dly_max cycles.
   int          core_dly_max = 3;
   logic [31:0] core_n;
   initial begin
      cif.core_done = 1'b0;
      cif.core_hash = '0;
      forever begin
         @(negedge clk);
         if (rst_n && cif.core_start) begin
            core_n = cif.core_nonce;
            repeat ($urandom_range(1, core_dly_max)) @(posedge clk);
            #1;
            cif.core_done = 1'b1;
            cif.core_hash = hash_of(core_n);
            @(posedge clk); #1;
            cif.core_done = 1'b0;
            cif.core_hash = {8{$urandom()}};
         end
      end
   end

   // Monitor: every job pulse and every busy fall is checked against the queues.
   logic prev_busy = 1'b0;
   res_t mon_r;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy <= 1'b0;
      end else begin
         if (cif.core_start) begin
            if (exp_nonce_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_core_start: got nonce %0h expected no job", cif.core_nonce);
            end else begin
               chk("core_nonce", 256'(cif.core_nonce), 256'(exp_nonce_q.pop_front()));
            end
         end
         if (prev_busy && !busy) begin
            if (exp_res_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_search_end: got busy fall expected none");
            end else begin
               mon_r = exp_res_q.pop_front();
               chk("found",       256'(found),       256'(mon_r.found));
               chk("found_nonce", 256'(found_nonce), 256'(mon_r.fn));
               chk("found_hash",  found_hash,        mon_r.fh);
               chk("exhausted",   256'(exhausted),   256'(mon_r.exh));
`ifdef MULTI_HIT_EN
               chk("hit_count",   256'(hit_count),   256'(mon_r.cnt));
`endif
            end
         end
         prev_busy <= busy;
      end
   end

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
      @(posedge clk); #1;
      nonce_start = s;
      nonce_end   = e;
      target      = t;
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      nonce_start = $urandom();
      nonce_end   = $urandom();
      target      = {8{$urandom()}};
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL %s_timeout: got busy=1 expected idle within 4000 cycles", name);
      end
      repeat (8) @(posedge clk);
   endtask

   task automatic run_search(input string name, input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] t);
      model_search(s, e, t);
      pulse_start(s, e, t);
      wait_idle(name);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish within 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  s;
      logic [255:0] t;
      int           n;

      #2;
      chk("rst_busy",        256'(busy),           256'(0));
      chk("rst_found",       256'(found),          256'(0));
      chk("rst_exhausted",   256'(exhausted),      256'(0));
      chk("rst_core_start",  256'(cif.core_start), 256'(0));
      chk("rst_core_nonce",  256'(cif.core_nonce), 256'(0));
      chk("rst_found_nonce", 256'(found_nonce),    256'(0));
      chk("rst_found_hash",  found_hash,           256'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Single nonce, everything hits; also start-to-core_start latency.
      model_search(32'd5, 32'd5, '1);
      pulse_start(32'd5, 32'd5, '1);
      @(posedge clk);
      @(negedge clk);
      chk("latency_core_start", 256'(cif.core_start), 256'(1));
      wait_idle("single");

      // Hit on nonce 12 inside 10..13.
      hmode = 1;
      hitset = '{32'd12};
      run_search("hit12", 32'd10, 32'd13, {8'h00, {248{1'b1}}});

      // Wrap through all-ones with no hits.
      hitset = '{};
      run_search("wrap", 32'hFFFF_FFFE, 32'h0000_0001, '0);

      // Two hits in 0..3; the first one is reported.
      hitset = '{32'd1, 32'd3};
      run_search("two_hits", 32'd0, 32'd3, {8'h00, {248{1'b1}}});

      // Abort together with a hitting core_done.
      hmode = 0;
      exp_nonce_q.push_back(32'd40);
      m.found = 1'b0;
      m.exh   = 1'b0;
      m.cnt   = '0;
      exp_res_q.push_back(m);
      pulse_start(32'd40, 32'd45, '1);
      n = 0;
      while (!cif.core_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("abort_saw_core_done", 256'(cif.core_done), 256'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 256'(busy), 256'(0));
      wait_idle("abort");

      // core_ready held low; a second start while busy must be ignored.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      model_search(32'd100, 32'd101, '0);
      pulse_start(32'd100, 32'd101, '0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("stall_no_core_start", 256'(cif.core_start), 256'(0));
         if (i == 3) begin
            @(posedge clk); #1;
            nonce_start = 32'd500;
            nonce_end   = 32'd500;
            start       = 1'b1;
            @(posedge clk); #1;
            start       = 1'b0;
         end
      end
      chk("stall_busy", 256'(busy), 256'(1));
      ready_mode = 0;
      wait_idle("stall");

      // Randomized searches.
      for (int i = 0; i < 24; i++) begin
         salt         = $urandom();
         ready_mode   = $urandom_range(0, 1);
         core_dly_max = $urandom_range(1, 4);
         s = $urandom();
         if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
         case ($urandom_range(0, 5))
            0:       t = '1;
            1:       t = '0;
            default: t = {$urandom(), {224{1'b1}}};
         endcase
         run_search("random", s, s + 32'($urandom_range(0, 9)), t);
      end

      // Asynchronous reset in the middle of a stalled search.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      pulse_start(32'd7, 32'd9, '1);
      repeat (2) @(posedge clk);
      #3;
      exp_nonce_q.delete();
      exp_res_q.delete();
      m = '0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy",        256'(busy),           256'(0));
      chk("async_rst_found_nonce", 256'(found_nonce),    256'(0));
      chk("async_rst_found_hash",  found_hash,           256'(0));
      chk("async_rst_core_nonce",  256'(cif.core_nonce), 256'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 0;
      hmode = 1;
      hitset = '{32'd21};
      run_search("after_reset", 32'd20, 32'd22, {8'h00, {248{1'b1}}});

      chk("nonce_queue_empty",  256'(exp_nonce_q.size()), 256'(0));
      chk("result_queue_empty", 256'(exp_res_q.size()),   256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
